// File: rtl/mda_vram_sequencer_pkg.sv
// Shared constants, slot-owner type and slot decode for the MDA VRAM sequencer.
package mda_seq_pkg;

    localparam int unsigned SEQ_W      = 5;
    localparam int unsigned CELL_STEPS = 18;
    localparam int unsigned LAST_STEP  = CELL_STEPS - 1;
    localparam int unsigned SLOT_CHAR  = 0;
    localparam int unsigned SLOT_ATT   = 4;
    localparam int unsigned SLOT_CPU0  = 8;
    localparam int unsigned SLOT_CPU1  = 12;
    localparam int unsigned SLOT_IDLE  = 16;

    typedef enum logic [1:0] {
        DISP_CHAR,
        DISP_ATT,
        CPU,
        IDLE
    } slot_owner_e;

    // Which requester owns the VRAM on a given cell step.
    function automatic slot_owner_e slot_owner(input logic [SEQ_W-1:0] seq);
        slot_owner_e owner;
        if (seq < SEQ_W'(SLOT_ATT)) begin
            owner = DISP_CHAR;
        end else if (seq < SEQ_W'(SLOT_CPU0)) begin
            owner = DISP_ATT;
        end else if (seq < SEQ_W'(SLOT_IDLE)) begin
            owner = CPU;
        end else begin
            owner = IDLE;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mda_vram_sequencer_if.sv
// CPU requester req/ack bus into the VRAM sequencer.
interface mda_vram_sequencer_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack
    );
endinterface

// File: rtl/mda_vram_sequencer_cpu_port.sv
// CPU side of the VRAM time-share: grant on steps 7/11, write strobe, read capture, ack.
module mda_cpu_port
    import mda_seq_pkg::*;
#(
    parameter int unsigned VRAM_LAT = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SEQ_W-1:0]    i_seq,
    input  logic [7:0]          i_vram_data,
    mda_vram_sequencer_if.slave cpu_bus,
    output logic                o_grant_c,
    output logic                o_vram_we,
    output logic [7:0]          o_vram_wdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_WAIT_DATA,
        ST_ACK
    } cpu_state_e;

    cpu_state_e       r_state;
    cpu_state_e       w_state_nxt;
    logic             r_is_write;
    logic             w_is_write_nxt;
    logic             r_slot1;
    logic             w_slot1_nxt;
    logic             r_ack;
    logic             w_ack_nxt;
    logic             r_we;
    logic             w_we_nxt;
    logic [7:0]       r_wdata;
    logic [7:0]       w_wdata_nxt;
    logic [7:0]       r_rdata;
    logic             w_capture;
    logic [SEQ_W-1:0] w_offset;

    // Position within the granted slot; only meaningful while a slot is owned.
    assign w_offset = i_seq - (r_slot1 ? SEQ_W'(SLOT_CPU1) : SEQ_W'(SLOT_CPU0));

    // State register and request latch; reset abandons any access without ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_is_write <= 1'b0;
            r_slot1    <= 1'b0;
            r_ack      <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= 8'h00;
            r_rdata    <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_is_write <= w_is_write_nxt;
            r_slot1    <= w_slot1_nxt;
            r_ack      <= w_ack_nxt;
            r_we       <= w_we_nxt;
            r_wdata    <= w_wdata_nxt;
            if (w_capture) begin
                r_rdata <= i_vram_data;
            end
        end
    end

    // Grant/ack sequencing; cpu_req is only looked at in IDLE, so the ack cycle never re-grants.
    always_comb begin
        w_state_nxt    = r_state;
        w_is_write_nxt = r_is_write;
        w_slot1_nxt    = r_slot1;
        w_wdata_nxt    = r_wdata;
        w_ack_nxt      = 1'b0;
        w_we_nxt       = 1'b0;
        w_capture      = 1'b0;
        o_grant_c      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_bus.cpu_req &&
                    ((i_seq == SEQ_W'(SLOT_CPU0 - 1)) || (i_seq == SEQ_W'(SLOT_CPU1 - 1)))) begin
                    o_grant_c      = 1'b1;
                    w_state_nxt    = ST_GRANTED;
                    w_is_write_nxt = cpu_bus.cpu_we;
                    w_slot1_nxt    = (i_seq == SEQ_W'(SLOT_CPU1 - 1));
                    w_we_nxt       = cpu_bus.cpu_we;
                    if (cpu_bus.cpu_we) begin
                        w_wdata_nxt = cpu_bus.cpu_wdata;
                    end
                end
            end
            ST_GRANTED, ST_WAIT_DATA: begin
                if (r_is_write) begin
                    w_state_nxt = ST_ACK;
                    w_ack_nxt   = 1'b1;
                end else if (w_offset == SEQ_W'(VRAM_LAT)) begin
                    w_capture   = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_WAIT_DATA;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_vram_we         = r_we;
    assign o_vram_wdata      = r_wdata;
    assign cpu_bus.cpu_ack   = r_ack;
    assign cpu_bus.cpu_rdata = r_rdata;

endmodule

// File: rtl/mda_vram_sequencer.sv
// Per-character cell sequencer: step counter, display/CPU VRAM slot mux and datapath strobes.
module mda_vram_sequencer
    import mda_seq_pkg::*;
#(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned VRAM_LAT     = 2,
    parameter int unsigned CHARROM_SLOT = 17,
    parameter int unsigned PIPE_SLOT    = 17
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-2:0]   disp_addr,
    output logic [SEQ_W-1:0]    clk_seq,
    output logic                crtc_tick,
    output logic [ADDR_W-1:0]   vram_addr,
    output logic                vram_we,
    output logic [7:0]          vram_wdata,
    input  logic [7:0]          vram_data,
    output logic                vram_read_char,
    output logic                vram_read_att,
    output logic                charrom_read,
    output logic                disp_pipeline,
    mda_vram_sequencer_if.slave cpu_bus
);

    logic [SEQ_W-1:0]  r_seq;
    logic [SEQ_W-1:0]  w_seq_nxt;
    logic [ADDR_W-2:0] r_idx;
    logic [ADDR_W-2:0] w_idx;
    logic [ADDR_W-1:0] r_vram_addr;
    logic              r_rd_char;
    logic              r_rd_att;
    logic              r_charrom;
    logic              r_pipe;
    logic              r_tick;
    logic              w_grant_c;
    slot_owner_e       w_owner_nxt;

    // Outputs are registered from the next step so they line up with clk_seq.
    assign w_seq_nxt   = (r_seq == SEQ_W'(LAST_STEP)) ? '0 : r_seq + SEQ_W'(1);
    assign w_idx       = (r_seq == SEQ_W'(LAST_STEP)) ? disp_addr : r_idx;
    assign w_owner_nxt = slot_owner(w_seq_nxt);

    // Cell step counter and character index latch at the end of the cell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq <= '0;
            r_idx <= '0;
        end else begin
            r_seq <= w_seq_nxt;
            if (r_seq == SEQ_W'(LAST_STEP)) begin
                r_idx <= disp_addr;
            end
        end
    end

    // VRAM address mux: display slots are fixed, CPU slot only on grant, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vram_addr <= '0;
        end else begin
            case (w_owner_nxt)
                DISP_CHAR: r_vram_addr <= {w_idx, 1'b0};
                DISP_ATT:  r_vram_addr <= {w_idx, 1'b1};
                CPU: begin
                    if (w_grant_c) begin
                        r_vram_addr <= cpu_bus.cpu_addr;
                    end
                end
                default: r_vram_addr <= r_vram_addr;
            endcase
        end
    end

    // One-cycle datapath strobes decoded from the upcoming step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_char <= 1'b0;
            r_rd_att  <= 1'b0;
            r_charrom <= 1'b0;
            r_pipe    <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_rd_char <= (w_seq_nxt == SEQ_W'(SLOT_CHAR + VRAM_LAT));
            r_rd_att  <= (w_seq_nxt == SEQ_W'(SLOT_ATT + VRAM_LAT));
            r_charrom <= (w_seq_nxt == SEQ_W'(CHARROM_SLOT));
            r_pipe    <= (w_seq_nxt == SEQ_W'(PIPE_SLOT));
            r_tick    <= (w_seq_nxt == SEQ_W'(LAST_STEP));
        end
    end

    mda_cpu_port #(
        .VRAM_LAT (VRAM_LAT)
    ) u_cpu_port (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_seq        (r_seq),
        .i_vram_data  (vram_data),
        .cpu_bus      (cpu_bus),
        .o_grant_c    (w_grant_c),
        .o_vram_we    (vram_we),
        .o_vram_wdata (vram_wdata)
    );

    assign clk_seq        = r_seq;
    assign vram_addr      = r_vram_addr;
    assign vram_read_char = r_rd_char;
    assign vram_read_att  = r_rd_att;
    assign charrom_read   = r_charrom;
    assign disp_pipeline  = r_pipe;
    assign crtc_tick      = r_tick;

endmodule
